// File: rtl/timer_mc_pkg.sv
// timer_mc shared definitions: register map, bit indices and bus helpers.
// Imported by every file of the multi-channel PWM timer.
package timer_mc_pkg;

  localparam logic [7:0] TIMER_MC_CTRL_ADDR   = 8'h00;
  localparam logic [7:0] TIMER_MC_PRE_ADDR    = 8'h04;
  localparam logic [7:0] TIMER_MC_TOP_ADDR    = 8'h08;
  localparam logic [7:0] TIMER_MC_COUNT_ADDR  = 8'h0C;
  localparam logic [7:0] TIMER_MC_STATUS_ADDR = 8'h10;
  localparam logic [7:0] TIMER_MC_IRQEN_ADDR  = 8'h14;
  localparam logic [7:0] TIMER_MC_CMP_BASE    = 8'h20;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int STAT_TOPF    = 0;
  localparam int STAT_CMPF    = 1;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8]
                          : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/timer_mc_if.sv
// enable/ready peripheral bus shared by the timer and its master.
// The slave pulses ready for one cycle per accepted access.
interface timer_mc_if;
  logic        enable;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] i_data;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] o_data;
  logic        bus_err;

  modport master (
    output enable, wr_en, addr, i_data, be,
    input  ready, o_data, bus_err
  );

  modport slave (
    input  enable, wr_en, addr, i_data, be,
    output ready, o_data, bus_err
  );
endinterface

// File: rtl/timer_mc_core.sv
// Timer datapath: prescaler, up or up/down counter, shadow latch,
// compare flags and registered PWM outputs.
module timer_mc_core
  import timer_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           mode,
  input  logic [PRE_W-1:0]               prescale,
  input  logic [CNT_W-1:0]               top_nxt,
  input  logic [NUM_CH-1:0][CNT_W-1:0]   cmp_nxt,
  input  logic                           cnt_wr,
  input  logic [CNT_W-1:0]               cnt_wdata,
  output logic [CNT_W-1:0]               count,
  output logic                           boundary,
  output logic [NUM_CH-1:0]              cmp_hit,
  output logic [NUM_CH-1:0]              pwm
);

  logic [PRE_W-1:0]             psc;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             cnt_nxt;
  logic [CNT_W-1:0]             top_act;
  logic [NUM_CH-1:0][CNT_W-1:0] cmp_act;
  logic                         dir_dn;
  logic                         dir_nxt;
  logic                         tick;

  assign count = cnt;
  assign tick  = en && (psc == prescale);

  always_comb begin
    cnt_nxt  = cnt;
    boundary = 1'b0;
    // a zero counter always restarts upward
    dir_nxt  = mode && dir_dn && (cnt != '0);
    if (cnt_wr) begin
      cnt_nxt = cnt_wdata;
    end else if (tick) begin
      if (!mode) begin
        if (cnt >= top_act) begin
          cnt_nxt  = '0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end else if (top_act == '0) begin
        cnt_nxt = '0;
      end else if (dir_nxt) begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          boundary = 1'b1;
          dir_nxt  = 1'b0;
        end
      end else if (cnt >= top_act) begin
        cnt_nxt = top_act - CNT_W'(1);
        dir_nxt = 1'b1;
        if (top_act == CNT_W'(1)) begin
          boundary = 1'b1;
          dir_nxt  = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cmp_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_hit[i] = tick && !cnt_wr
                && (cnt_nxt != cnt)
                && (cnt_nxt == cmp_act[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc     <= '0;
      cnt     <= '0;
      dir_dn  <= 1'b0;
      top_act <= '0;
      cmp_act <= '0;
      pwm     <= '0;
    end else begin
      if (!en || cnt_wr || tick) psc <= '0;
      else                       psc <= psc + PRE_W'(1);
      cnt    <= cnt_nxt;
      dir_dn <= dir_nxt;
      if (!en || boundary) begin
        top_act <= top_nxt;
        cmp_act <= cmp_nxt;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        pwm[i] <= en && (cnt < cmp_act[i]);
      end
    end
  end

endmodule

// File: rtl/timer_mc.sv
// Multi-channel PWM timer: bus decode, register file and irq,
// wrapped around the shared-counter timer_mc_core.
module timer_mc
  import timer_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  timer_mc_if.slave         bus,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm
);

  localparam int SW       = NUM_CH + 1;
  localparam int CMP_WIDX = int'(TIMER_MC_CMP_BASE[7:2]);

  logic [2:0]                   ctrl;
  logic [PRE_W-1:0]             prescale;
  logic [CNT_W-1:0]             top_sh;
  logic [CNT_W-1:0]             top_nxt;
  logic [CNT_W-1:0]             count;
  logic [SW-1:0]                status;
  logic [SW-1:0]                irq_en;
  logic [SW-1:0]                clr;
  logic [NUM_CH-1:0][CNT_W-1:0] cmp_sh;
  logic [NUM_CH-1:0][CNT_W-1:0] cmp_nxt;
  logic [NUM_CH-1:0]            cmp_hit;
  logic [NUM_CH-1:0]            sel_cmp;
  logic                         boundary;

  logic        acc, wr, mapped;
  logic [5:0]  widx;
  logic [31:0] rdata, cmp_rd;
  logic        sel_ctrl, sel_pre, sel_top;
  logic        sel_cnt, sel_stat, sel_ien;
  logic        unused_addr;

  assign acc  = bus.enable && !bus.ready;
  assign wr   = acc && bus.wr_en;
  assign widx = bus.addr[7:2];
  assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

  assign sel_ctrl = widx == TIMER_MC_CTRL_ADDR[7:2];
  assign sel_pre  = widx == TIMER_MC_PRE_ADDR[7:2];
  assign sel_top  = widx == TIMER_MC_TOP_ADDR[7:2];
  assign sel_cnt  = widx == TIMER_MC_COUNT_ADDR[7:2];
  assign sel_stat = widx == TIMER_MC_STATUS_ADDR[7:2];
  assign sel_ien  = widx == TIMER_MC_IRQEN_ADDR[7:2];

  always_comb begin
    sel_cmp = '0;
    cmp_rd  = '0;
    cmp_nxt = cmp_sh;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_cmp[i] = widx == 6'(CMP_WIDX + i);
      if (sel_cmp[i]) cmp_rd = 32'(cmp_sh[i]);
      if (wr && sel_cmp[i])
        cmp_nxt[i] = CNT_W'(be_merge(32'(cmp_sh[i]),
                                     bus.i_data, bus.be));
    end
  end

  assign top_nxt = (wr && sel_top)
    ? CNT_W'(be_merge(32'(top_sh), bus.i_data, bus.be))
    : top_sh;

  assign clr = (wr && sel_stat)
    ? SW'(bus.i_data & be_mask(bus.be)) : '0;

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    unique case (1'b1)
      sel_ctrl: rdata = 32'(ctrl);
      sel_pre:  rdata = 32'(prescale);
      sel_top:  rdata = 32'(top_sh);
      sel_cnt:  rdata = 32'(count);
      sel_stat: rdata = 32'(status);
      sel_ien:  rdata = 32'(irq_en);
      |sel_cmp: rdata = cmp_rd;
      default:  mapped = 1'b0;
    endcase
  end

  timer_mc_core #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRE_W  (PRE_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (ctrl[CTRL_EN]),
    .mode      (ctrl[CTRL_MODE]),
    .prescale  (prescale),
    .top_nxt   (top_nxt),
    .cmp_nxt   (cmp_nxt),
    .cnt_wr    (wr && sel_cnt),
    .cnt_wdata (CNT_W'(be_merge(32'(count),
                                bus.i_data, bus.be))),
    .count     (count),
    .boundary  (boundary),
    .cmp_hit   (cmp_hit),
    .pwm       (pwm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl        <= '0;
      prescale    <= '0;
      top_sh      <= '0;
      cmp_sh      <= '0;
      status      <= '0;
      irq_en      <= '0;
      irq         <= 1'b0;
      bus.ready   <= 1'b0;
      bus.o_data  <= '0;
      bus.bus_err <= 1'b0;
    end else begin
      // a bus write to CTRL overrides the one-shot stop
      if (wr && sel_ctrl)
        ctrl <= 3'(be_merge(32'(ctrl), bus.i_data, bus.be));
      else if (boundary && ctrl[CTRL_ONESHOT])
        ctrl[CTRL_EN] <= 1'b0;
      if (wr && sel_pre)
        prescale <= PRE_W'(be_merge(32'(prescale),
                                    bus.i_data, bus.be));
      if (wr && sel_ien)
        irq_en <= SW'(be_merge(32'(irq_en),
                               bus.i_data, bus.be));
      top_sh <= top_nxt;
      cmp_sh <= cmp_nxt;
      status <= (status & ~clr) | {cmp_hit, boundary};
      irq    <= |(status & irq_en);
      bus.ready   <= acc;
      bus.o_data  <= (acc && !bus.wr_en) ? rdata : '0;
      bus.bus_err <= acc && !mapped;
    end
  end

endmodule

// File: tb/tb_timer_mc.sv
// Directed self-checking bench for timer_mc (NUM_CH=4, CNT_W=16).
// Walks a linear sequence of bus accesses and PWM/irq observations.
module tb_timer_mc;

  logic       clk;
  logic       rst_n;
  logic       irq;
  logic [3:0] pwm;
  logic       irq_at_ready;
  int         tests;
  int         fails;

  timer_mc_if bus ();

  timer_mc #(
    .NUM_CH (4),
    .CNT_W  (16),
    .PRE_W  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .irq   (irq),
    .pwm   (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // called at a negedge; returns 1.5 cycles after accept
  task automatic xfer(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  b,
    output logic [31:0] q,
    output logic        e
  );
    int n;
    bus.enable = 1'b1;
    bus.wr_en  = w;
    bus.addr   = a;
    bus.i_data = d;
    bus.be     = b;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ready && n < 4);
    check("ready", 32'(bus.ready), 32'd1);
    q = bus.o_data;
    e = bus.bus_err;
    irq_at_ready = irq;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.wr_en  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d
  );
    logic [31:0] q;
    logic        e;
    xfer(1'b1, a, d, 4'hF, q, e);
  endtask

  task automatic rd(
    input logic [31:0] a,
    input logic [31:0] exp,
    input string       tag
  );
    logic [31:0] q;
    logic        e;
    xfer(1'b0, a, 32'd0, 4'h0, q, e);
    check(tag, q, exp);
    check({tag, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic count_pwm(
    input  int ch,
    input  int n,
    output int hi
  );
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm[ch]) hi++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    int          hi;
    int          n;
    tests = 0;
    fails = 0;
    irq_at_ready = 1'b0;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.wr_en  = 1'b0;
    bus.addr   = '0;
    bus.i_data = '0;
    bus.be     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_err", 32'(bus.bus_err), 32'd0);
    check("rst_odata", bus.o_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h00, 32'd0, "rst_ctrl");
    rd(32'h0C, 32'd0, "rst_count");
    rd(32'h10, 32'd0, "rst_status");

    // byte enables and register width
    xfer(1'b1, 32'h04, 32'h0000AB03, 4'b0001, q, e);
    rd(32'h04, 32'd3, "pre_be");
    wr(32'h08, 32'hABCD00FF);
    rd(32'h08, 32'h00FF, "top_width");
    wr(32'h20, 32'd64);

    // up mode, 1024-clock period, 256 clocks high
    wr(32'h00, 32'd1);
    count_pwm(0, 2048, hi);
    check("up_pwm0_hi", 32'(hi), 32'd512);
    rd(32'h10, 32'h1F, "up_status");

    // CMP update mid-period waits for the boundary
    wr(32'h0C, 32'd100);
    wr(32'h20, 32'd128);
    count_pwm(0, 100, hi);
    check("shadow_hold", 32'(hi), 32'd0);
    rd(32'h20, 32'd128, "cmp0_shadow");
    repeat (700) @(negedge clk);
    count_pwm(0, 2048, hi);
    check("shadow_new", 32'(hi), 32'd1024);

    // up/down: 20-clock period, counter<5 on 9 ticks
    wr(32'h00, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd10);
    wr(32'h20, 32'd0);
    wr(32'h24, 32'd5);
    wr(32'h0C, 32'd0);
    wr(32'h10, 32'h1F);
    rd(32'h10, 32'd0, "w1c_idle");
    check("stop_pwm", 32'(pwm), 32'd0);
    wr(32'h00, 32'd3);
    count_pwm(1, 200, hi);
    check("ud_pwm1_hi", 32'(hi), 32'd90);

    // up/down one-shot ends only at the downward zero
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h10, 32'h1F);
    wr(32'h00, 32'd7);
    repeat (12) @(negedge clk);
    rd(32'h00, 32'd7, "ud_os_mid");
    repeat (20) @(negedge clk);
    rd(32'h00, 32'd6, "ud_os_end");
    rd(32'h0C, 32'd0, "ud_os_cnt");
    rd(32'h10, 32'h1F, "ud_os_stat");

    // up one-shot, TOP=7: one 8-clock period
    wr(32'h00, 32'd0);
    wr(32'h10, 32'h1F);
    wr(32'h08, 32'd7);
    wr(32'h20, 32'd4);
    wr(32'h00, 32'd5);
    count_pwm(0, 40, hi);
    check("os_pwm0_hi", 32'(hi), 32'd4);
    rd(32'h00, 32'd4, "os_ctrl");
    rd(32'h0C, 32'd0, "os_cnt");
    rd(32'h10, 32'h1F, "os_stat");
    check("os_pwm_low", 32'(pwm), 32'd0);

    // irq on TOPF, cleared by W1C
    wr(32'h10, 32'h1F);
    wr(32'h14, 32'd1);
    wr(32'h00, 32'd1);
    n = 0;
    while (!irq && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise", 32'(irq), 32'd1);
    wr(32'h00, 32'd0);
    wr(32'h10, 32'd1);
    check("irq_at_ready", 32'(irq_at_ready), 32'd1);
    check("irq_drop", 32'(irq), 32'd0);

    // W1C landing on a boundary edge loses to the set
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'd1);
    repeat (6) @(negedge clk);
    wr(32'h10, 32'd1);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, q, e);
    check("w1c_vs_set", q & 32'd1, 32'd1);
    wr(32'h00, 32'd0);

    // unmapped read with enable held 3 cycles
    bus.enable = 1'b1;
    bus.wr_en  = 1'b0;
    bus.addr   = 32'h3C;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("unm_ready", 32'(bus.ready),
            32'((i % 2) == 0));
      check("unm_err", 32'(bus.bus_err),
            32'((i % 2) == 0));
      check("unm_odata", bus.o_data, 32'd0);
      @(negedge clk);
      if (i == 2) bus.enable = 1'b0;
    end

    // reset during a pending ready
    bus.enable = 1'b1;
    bus.addr   = 32'h00;
    @(posedge clk);
    #1;
    check("pre_rst_ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
